// File: rtl/aes_disp_pkg.sv
// Shared types and constants for the AES block byte display path.
package aes_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } disp_state_t;

  localparam int BLOCK_BYTES   = 16;
  localparam int DWELL_DEFAULT = 50_000_000;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] block_byte(input logic [127:0] blk, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (idx == 4'(i)) b = blk[127-8*i -: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/disp_dwell_timer.sv
// Dwell counter for the byte display; tick marks the last cycle of a dwell period.
module disp_dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TC) ? '0 : count + CW'(1);
    end
  end

  assign tick = en && (count == TC);

endmodule

// File: rtl/block_byte_scanner.sv
// Steps through the 16 bytes of a latched AES block, one byte per dwell period or step pulse.
// Build option DISPLAY_LOOP_EN: wrap from byte 15 back to byte 0 instead of holding.
//
// state | meaning
// IDLE  | no block yet, byte_out = 0, ready for a block
// SHOW  | cycling through bytes of the latched block
// HOLD  | last byte shown, parked on byte 15 until a new block
module block_byte_scanner
  import aes_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = DWELL_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] blk_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic         step,
  output logic [7:0]   byte_out,
  output logic [3:0]   byte_idx,
  output logic         busy,
  output logic         done
);

  disp_state_t  state, state_n;
  logic [127:0] blk_q, blk_n;
  logic [7:0]   byte_q, byte_n;
  logic [3:0]   idx_q, idx_n;
  logic         done_q, done_n;
  logic         tick, advance, handshake, last_byte, tmr_clr, tmr_en;

  disp_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk  (clk),
    .reset(reset),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      blk_q  <= '0;
      byte_q <= 8'h00;
      idx_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      blk_q  <= blk_n;
      byte_q <= byte_n;
      idx_q  <= idx_n;
      done_q <= done_n;
    end
  end

`ifdef DISPLAY_LOOP_EN
  assign blk_ready = 1'b1;
`else
  assign blk_ready = (state != SHOW);
`endif

  assign tmr_en    = (state == SHOW);
  assign advance   = (state == SHOW) && (tick || step);
  assign last_byte = (idx_q == 4'(BLOCK_BYTES - 1));
  assign handshake = blk_valid && blk_ready;

  always_comb begin
    state_n = state;
    blk_n   = blk_q;
    byte_n  = byte_q;
    idx_n   = idx_q;
    done_n  = 1'b0;
    tmr_clr = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (handshake) begin
          state_n = SHOW;
          blk_n   = blk_in;
          idx_n   = 4'd0;
          byte_n  = blk_in[127:120];
          tmr_clr = 1'b1;
        end
      end
      SHOW: begin
        if (advance) begin
          tmr_clr = 1'b1;
          idx_n   = idx_q + 4'd1;
          byte_n  = block_byte(blk_q, idx_q + 4'd1);
          if (last_byte) begin
            done_n = 1'b1;
`ifdef DISPLAY_LOOP_EN
            state_n = SHOW;
`else
            state_n = HOLD;
            idx_n   = idx_q;
            byte_n  = byte_q;
`endif
          end
        end
`ifdef DISPLAY_LOOP_EN
        // A new block restarts the scan; a coinciding end-of-block done is kept.
        if (handshake) begin
          blk_n   = blk_in;
          idx_n   = 4'd0;
          byte_n  = blk_in[127:120];
          tmr_clr = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_out = byte_q;
  assign byte_idx = idx_q;
  assign busy     = (state == SHOW);
  assign done     = done_q;

endmodule
